// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone arbiter, N masters onto one slave.
// Ports: clk_i/rst_ni, m_* per-master bus, s_* slave bus, gnt_o, busy_o.
module wb_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_MASTERS-1:0]             m_cyc_i,
  input  logic [NUM_MASTERS-1:0]             m_stb_i,
  input  logic [NUM_MASTERS-1:0]             m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]  m_dat_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
  output logic [DATA_WIDTH-1:0]              m_dat_o,
  output logic [NUM_MASTERS-1:0]             m_ack_o,
  output logic [NUM_MASTERS-1:0]             m_err_o,
  output logic                               s_cyc_o,
  output logic                               s_stb_o,
  output logic                               s_we_o,
  output logic [ADDR_WIDTH-1:0]              s_adr_o,
  output logic [DATA_WIDTH-1:0]              s_dat_o,
  output logic [DATA_WIDTH/8-1:0]            s_sel_o,
  input  logic [DATA_WIDTH-1:0]              s_dat_i,
  input  logic                               s_ack_i,
  output logic [NUM_MASTERS-1:0]             gnt_o,
  output logic                               busy_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IW-1:0]          rr_q, rr_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [1:0]             rst_sync;
  logic                   rst_n;
  logic [IW-1:0]          g_idx;
  logic [IW-1:0]          win_idx;
  logic                   active;
  logic                   stall;
  logic                   timeout;

  // Assert immediately, release two edges after rst_ni rises.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (gnt_q[i]) g_idx = IW'(i);
  end

  // First requester at or above rr_q, wrapping.
  always_comb begin
    logic found;
    found   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found &&
          m_cyc_i[(int'(rr_q) + i) % NUM_MASTERS]) begin
        found   = 1'b1;
        win_idx = IW'((int'(rr_q) + i) % NUM_MASTERS);
      end
    end
  end

  assign active  = (state_q == GRANT) && m_cyc_i[g_idx];
  assign stall   = active && m_stb_i[g_idx] && !s_ack_i;
  assign timeout = stall && (cnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          state_d = GRANT;
          gnt_d   = NUM_MASTERS'(1) << win_idx;
          rr_d    = (win_idx == IW'(NUM_MASTERS - 1))
                    ? '0 : win_idx + 1'b1;
        end
      end
      GRANT: begin
        if (!m_cyc_i[g_idx]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (stall && !timeout) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    s_cyc_o = active;
    s_stb_o = active && m_stb_i[g_idx] && !timeout;
    s_we_o  = active && m_we_i[g_idx];
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (state_q == GRANT) begin
      s_adr_o = m_adr_i[g_idx*ADDR_WIDTH +: ADDR_WIDTH];
      s_dat_o = m_dat_i[g_idx*DATA_WIDTH +: DATA_WIDTH];
      s_sel_o = m_sel_i[g_idx*SW +: SW];
    end
  end

  assign m_ack_o = (active && s_ack_i) ? gnt_q : '0;
  assign m_err_o = timeout ? gnt_q : '0;
  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt_q;
  assign busy_o  = (state_q == GRANT);

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4, number of requesting Wishbone masters (2..8).
REQ-002 Parameter ADDR_WIDTH, default 32, address bus width.
REQ-003 Parameter DATA_WIDTH, default 32, data bus width (multiple of 8).
REQ-004 Parameter TIMEOUT, default 255, maximum stall cycles before a bus error (1..65535).
REQ-005 The block SHALL use one clock, clk_i, and an asynchronous active-low reset, rst_ni.
REQ-006 Ports SHALL be: clk_i in 1 clock; rst_ni in 1 async active-low reset.
REQ-007 m_cyc_i, m_stb_i, m_we_i in NUM_MASTERS; m_adr_i in NUM_MASTERS*ADDR_WIDTH; m_dat_i in NUM_MASTERS*DATA_WIDTH; m_sel_i in NUM_MASTERS*(DATA_WIDTH/8). These are the per-master requests; master k occupies slice k.
REQ-008 m_dat_o out DATA_WIDTH, shared read data; m_ack_o, m_err_o out NUM_MASTERS, per-master terminations.
REQ-009 s_cyc_o, s_stb_o, s_we_o out 1; s_adr_o out ADDR_WIDTH; s_dat_o out DATA_WIDTH; s_sel_o out DATA_WIDTH/8. These are the slave-side request.
REQ-010 s_dat_i in DATA_WIDTH; s_ack_i in 1, slave read data and acknowledge.
REQ-011 gnt_o out NUM_MASTERS, one-hot current grant; busy_o out 1, high in GRANT.

Function
REQ-012 FSM states SHALL be IDLE and GRANT only.
REQ-013 IDLE: if any m_cyc_i is high, the block SHALL register the winner into gnt_o and enter GRANT on the next edge. s_cyc_o is 0 during the arbitration cycle.
REQ-014 Winner SHALL be the first requester at or after index rr_ptr, searching upward modulo NUM_MASTERS.
REQ-015 rr_ptr SHALL update to (granted index + 1) mod NUM_MASTERS when the grant is issued. Wrap from NUM_MASTERS-1 goes to 0.
REQ-016 GRANT: s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o and s_sel_o SHALL combinationally equal the granted master's inputs.
REQ-017 GRANT: m_ack_o[g] SHALL equal s_ack_i, and all other m_ack_o bits SHALL be 0. m_dat_o SHALL equal s_dat_i in every state.
REQ-018 The grant SHALL be held for the whole cycle (multiple stb beats allowed) while m_cyc_i[g] is high. Other requests are ignored and see no ack.
REQ-019 When m_cyc_i[g] falls in GRANT, the block SHALL return to IDLE on the next edge and clear gnt_o. This gives a minimum of one idle cycle between grants.
REQ-020 A stall counter (16 bit) SHALL increment each GRANT cycle with s_stb_o=1 and s_ack_i=0. It SHALL clear on ack, when stb is low, and in IDLE.
REQ-021 When the counter reaches TIMEOUT, the block SHALL pulse m_err_o[g] for one cycle, force s_stb_o=0 that cycle, and clear the counter. The grant is retained until cyc drops.
REQ-022 If s_ack_i and a timeout coincide, the ack SHALL win and no err is issued.
REQ-023 If the granted master drops cyc while stb is high, the slave request SHALL drop combinationally in the same cycle and no ack is forwarded.
REQ-024 m_err_o SHALL be 0 outside the timeout pulse. m_ack_o SHALL be 0 in IDLE.

Reset
REQ-025 When rst_ni is asserted low, the block SHALL asynchronously force: state IDLE, gnt_o=0, rr_ptr=0, stall counter=0, busy_o=0.
REQ-026 During reset, all s_*_o control outputs, m_ack_o and m_err_o SHALL be 0.
REQ-027 Reset asserted mid-transfer SHALL abort the grant with no ack or err forwarded. Arbitration restarts from master 0 after deassertion.
REQ-028 Reset deassertion SHALL be synchronized internally, with release on a clk_i rising edge.

Verification
REQ-029 Single request: after reset, m_cyc_i=0001 with stb, and slave acks on the 2nd GRANT cycle -> gnt_o=0001 one cycle after cyc, m_ack_o=0001 for exactly one cycle, back to IDLE one cycle after cyc drops.
REQ-030 Round-robin: all four cyc held high, each master drops cyc after one ack -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-031 Wrap and skip: rr_ptr=3, requests from masters 1 and 2 only -> master 1 granted, rr_ptr becomes 2.
REQ-032 Timeout: TIMEOUT=4, slave never acks -> m_err_o[g] pulses on the 4th stall cycle with s_stb_o=0 that cycle. A second pulse follows 4 cycles later if stb is held.
REQ-033 Ack/timeout collision: s_ack_i arrives on the TIMEOUT-th stall cycle -> ack forwarded, no err, counter cleared.
REQ-034 Reset mid-burst: rst_ni low during GRANT of master 2 -> gnt_o=0 and s_cyc_o=0 immediately; after release with cyc 2 and 0 high, master 0 is granted first.
